// File: rtl/mem_arbiter.sv
// Arbitrates one variable-latency memory port between instruction fetch and data access.
// Data wins by default; a saturating streak counter forces a fetch after STARVE_LIMIT data grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_done,
    output logic [31:0]       o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_wr,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [31:0]       i_d_wdata,
    output logic              o_d_done,
    output logic [31:0]       o_d_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    input  logic [31:0]       i_mem_rdata,
    input  logic              i_mem_done
);

    localparam int            SW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] ONE   = SW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [SW-1:0]     streak_q,   streak_d;
    logic              if_req_q,   d_req_q;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [31:0]       wdata_q,    wdata_d;
    logic              mem_rd_q,   mem_rd_d;
    logic              mem_wr_q,   mem_wr_d;
    logic              if_done_q,  if_done_d;
    logic              d_done_q,   d_done_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q,  d_rdata_d;

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            streak_q   <= '0;
            if_req_q   <= 1'b0;
            d_req_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0000_0000;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            if_rdata_q <= 32'h0000_0000;
            d_rdata_q  <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            if_req_q   <= i_if_req;
            d_req_q    <= i_d_req;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Arbitration, access sequencing and response capture.
    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                // Fetch only wins a contested cycle once its streak of losses hits the limit.
                if (d_req_q && (!if_req_q || (streak_q != LIMIT))) begin
                    state_d  = S_DATA;
                    addr_d   = i_d_addr;
                    wdata_d  = i_d_wdata;
                    mem_wr_d = i_d_wr;
                    mem_rd_d = !i_d_wr;
                    if (if_req_q) begin
                        streak_d = streak_q + ONE;
                    end else begin
                        streak_d = '0;
                    end
                end else if (if_req_q) begin
                    state_d  = S_FETCH;
                    addr_d   = i_if_addr;
                    mem_rd_d = 1'b1;
                    mem_wr_d = 1'b0;
                    streak_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (i_mem_done) begin
                    state_d    = S_RESP;
                    mem_rd_d   = 1'b0;
                    mem_wr_d   = 1'b0;
                    if_rdata_d = i_mem_rdata;
                    if_done_d  = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DATA: begin
                if (i_mem_done) begin
                    state_d  = S_RESP;
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    d_done_d = 1'b1;
                    if (mem_rd_q) begin
                        d_rdata_d = i_mem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_rd    = mem_rd_q;
    assign o_mem_wr    = mem_wr_q;
    assign o_if_done   = if_done_q;
    assign o_d_done    = d_done_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a memory model answers strobes, expected accesses and
// responses are queued by each scenario task and compared as the arbiter produces them.
module tb_mem_arbiter;

    localparam int AW = 16;

    logic          clk         = 1'b0;
    logic          i_rst       = 1'b1;
    logic          i_if_req    = 1'b0;
    logic [AW-1:0] i_if_addr   = 16'h0000;
    logic          i_d_req     = 1'b0;
    logic          i_d_wr      = 1'b0;
    logic [AW-1:0] i_d_addr    = 16'h0000;
    logic [31:0]   i_d_wdata   = 32'h0000_0000;
    logic [31:0]   i_mem_rdata = 32'h0000_0000;
    logic          i_mem_done  = 1'b0;
    logic          o_if_done,  o_d_done, o_mem_rd, o_mem_wr;
    logic [31:0]   o_if_rdata, o_d_rdata, o_mem_wdata;
    logic [AW-1:0] o_mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_done(o_if_done), .o_if_rdata(o_if_rdata),
        .i_d_req(i_d_req), .i_d_wr(i_d_wr), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
        .o_d_done(o_d_done), .o_d_rdata(o_d_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr),
        .i_mem_rdata(i_mem_rdata), .i_mem_done(i_mem_done)
    );

    typedef struct packed { logic wr; logic [15:0] addr; logic [31:0] wdata; } acc_t;
    typedef struct packed { logic is_d; logic [31:0] rdata; } rsp_t;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   mem_lat  = 1;
    int   d_left   = 0;
    int   if_left  = 0;
    bit   spur_req = 1'b0;
    logic [31:0] last_if_rd = 32'h0000_0000;
    logic [31:0] last_d_rd  = 32'h0000_0000;

    int          mon_cnt  = 0;
    logic        mon_prev = 1'b0;
    logic        mon_strb;
    logic [15:0] mon_addr = 16'h0000;
    acc_t        mon_ea;
    rsp_t        mon_er;
    logic [31:0] mon_rd;

    function automatic logic [31:0] memval(input logic [15:0] a);
        if (a == 16'h0010) return 32'hDEAD_BEEF;
        return {a ^ 16'h5A5A, a};
    endfunction

    // Memory model, requester release and scoreboard comparison, all on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            mon_strb = o_mem_rd | o_mem_wr;
            if (i_rst) begin
                mon_cnt    = 0;
                mon_prev   = 1'b0;
                i_mem_done = 1'b0;
            end else begin
                if (mon_strb && !mon_prev) begin
                    n_checks++;
                    if (exp_acc.size() == 0) begin
                        $display("FAIL acc_unexpected: got rd=%b wr=%b addr=%h, required no access", o_mem_rd, o_mem_wr, o_mem_addr);
                    end else begin
                        mon_ea = exp_acc.pop_front();
                        if (o_mem_wr !== mon_ea.wr || o_mem_rd !== !mon_ea.wr || o_mem_addr !== mon_ea.addr ||
                            (mon_ea.wr && o_mem_wdata !== mon_ea.wdata))
                            $display("FAIL acc_match: got wr=%b rd=%b addr=%h wdata=%h, required wr=%b addr=%h wdata=%h",
                                     o_mem_wr, o_mem_rd, o_mem_addr, o_mem_wdata, mon_ea.wr, mon_ea.addr, mon_ea.wdata);
                        else n_pass++;
                    end
                    mon_addr = o_mem_addr;
                end else if (mon_strb) begin
                    n_checks++;
                    if (o_mem_addr !== mon_addr)
                        $display("FAIL addr_stable: got %h, required %h", o_mem_addr, mon_addr);
                    else n_pass++;
                end
                if (o_if_done || o_d_done) begin
                    n_checks++;
                    if (o_if_done && o_d_done) begin
                        $display("FAIL done_overlap: got both done pulses, required one");
                    end else if (exp_rsp.size() == 0) begin
                        $display("FAIL rsp_unexpected: got if_done=%b d_done=%b, required none", o_if_done, o_d_done);
                    end else begin
                        mon_er = exp_rsp.pop_front();
                        mon_rd = o_d_done ? o_d_rdata : o_if_rdata;
                        if (o_d_done !== mon_er.is_d || mon_rd !== mon_er.rdata)
                            $display("FAIL rsp_match: got is_d=%b rdata=%h, required is_d=%b rdata=%h",
                                     o_d_done, mon_rd, mon_er.is_d, mon_er.rdata);
                        else n_pass++;
                    end
                    if (o_d_done) begin
                        d_left--;
                        if (d_left <= 0) i_d_req = 1'b0;
                    end
                    if (o_if_done) begin
                        if_left--;
                        if (if_left <= 0) i_if_req = 1'b0;
                    end
                end
                if (mon_strb) begin
                    mon_cnt++;
                    if (mon_cnt >= mem_lat) begin
                        i_mem_done  = 1'b1;
                        i_mem_rdata = o_mem_wr ? 32'hFFFF_0000 : memval(o_mem_addr);
                        mon_cnt     = 0;
                    end else begin
                        i_mem_done = 1'b0;
                    end
                end else begin
                    mon_cnt = 0;
                    if (spur_req) begin
                        i_mem_done  = 1'b1;
                        i_mem_rdata = 32'hCAFE_F00D;
                        spur_req    = 1'b0;
                    end else begin
                        i_mem_done = 1'b0;
                    end
                end
                mon_prev = mon_strb;
            end
        end
    end

    task automatic drain(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (exp_acc.size() == 0 && exp_rsp.size() == 0 && !i_if_req && !i_d_req) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [133:0] outs;
        repeat (3) @(negedge clk);
        outs = {o_if_done, o_d_done, o_mem_rd, o_mem_wr, o_mem_addr, o_mem_wdata, o_if_rdata, o_d_rdata};
        n_checks++;
        if (outs !== 134'd0) $display("FAIL reset_outputs: got %h, required 0", outs);
        else n_pass++;
        i_rst = 1'b0;
        repeat (2) @(negedge clk);
        outs = {o_if_done, o_d_done, o_mem_rd, o_mem_wr, o_mem_addr, o_mem_wdata, o_if_rdata, o_d_rdata};
        n_checks++;
        if (outs !== 134'd0) $display("FAIL idle_outputs: got %h, required 0", outs);
        else n_pass++;
    endtask

    task automatic test_single_fetch();
        int rd_cycles = 0;
        int wr_seen   = 0;
        int done_cyc  = -1;
        int done_cnt  = 0;
        bit ok;
        mem_lat = 3;
        if_left = 1;
        exp_acc.push_back(acc_t'{1'b0, 16'h0010, 32'h0000_0000});
        exp_rsp.push_back(rsp_t'{1'b0, 32'hDEAD_BEEF});
        @(negedge clk);
        i_if_addr = 16'h0010;
        i_if_req  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (o_mem_rd) rd_cycles++;
            if (o_mem_wr) wr_seen++;
            if (o_if_done) begin done_cyc = c; done_cnt++; end
        end
        n_checks++;
        if (rd_cycles !== 3) $display("FAIL fetch_rd_cycles: got %0d, required 3", rd_cycles);
        else n_pass++;
        n_checks++;
        if (done_cyc !== 5 || done_cnt !== 1) $display("FAIL fetch_done_cycle: got cycle %0d count %0d, required cycle 5 count 1", done_cyc, done_cnt);
        else n_pass++;
        n_checks++;
        if (wr_seen !== 0) $display("FAIL fetch_no_write: got %0d write cycles, required 0", wr_seen);
        else n_pass++;
        n_checks++;
        if (o_if_rdata !== 32'hDEAD_BEEF) $display("FAIL fetch_rdata: got %h, required deadbeef", o_if_rdata);
        else n_pass++;
        last_if_rd = 32'hDEAD_BEEF;
        drain(50, ok);
        n_checks++;
        if (!ok) $display("FAIL fetch_drain: got timeout, required completion");
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        bit found = 1'b0;
        bit ok;
        mem_lat = 2;
        d_left  = 1;
        if_left = 1;
        exp_acc.push_back(acc_t'{1'b1, 16'h0100, 32'h1234_5678});
        exp_acc.push_back(acc_t'{1'b0, 16'h0004, 32'h0000_0000});
        exp_rsp.push_back(rsp_t'{1'b1, last_d_rd});
        exp_rsp.push_back(rsp_t'{1'b0, memval(16'h0004)});
        @(negedge clk);
        i_if_addr = 16'h0004;
        i_d_addr  = 16'h0100;
        i_d_wdata = 32'h1234_5678;
        i_d_wr    = 1'b1;
        i_if_req  = 1'b1;
        i_d_req   = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (o_mem_rd || o_mem_wr) found = 1'b1;
        end
        n_checks++;
        if (!found || o_mem_wr !== 1'b1 || o_mem_wdata !== 32'h1234_5678)
            $display("FAIL data_first: got found=%b wr=%b wdata=%h, required wr=1 wdata=12345678", found, o_mem_wr, o_mem_wdata);
        else n_pass++;
        last_if_rd = memval(16'h0004);
        drain(80, ok);
        n_checks++;
        if (!ok) $display("FAIL simul_drain: got timeout, required completion");
        else n_pass++;
        i_d_wr = 1'b0;
    endtask

    task automatic test_addr_change();
        bit found = 1'b0;
        bit ok;
        mem_lat = 4;
        d_left  = 1;
        exp_acc.push_back(acc_t'{1'b0, 16'h0300, 32'h0000_0000});
        exp_rsp.push_back(rsp_t'{1'b1, memval(16'h0300)});
        @(negedge clk);
        i_d_wr   = 1'b0;
        i_d_addr = 16'h0300;
        i_d_req  = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (o_mem_rd) found = 1'b1;
        end
        i_d_addr = 16'h0FFF;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (!found || o_mem_rd !== 1'b1 || o_mem_addr !== 16'h0300)
            $display("FAIL addr_latched: got found=%b rd=%b addr=%h, required rd=1 addr=0300", found, o_mem_rd, o_mem_addr);
        else n_pass++;
        last_d_rd = memval(16'h0300);
        drain(50, ok);
        n_checks++;
        if (!ok) $display("FAIL addr_drain: got timeout, required completion");
        else n_pass++;
    endtask

    task automatic test_starvation();
        bit ok;
        mem_lat = 2;
        d_left  = 8;
        if_left = 2;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                exp_acc.push_back(acc_t'{1'b0, 16'h0200, 32'h0000_0000});
                exp_rsp.push_back(rsp_t'{1'b1, memval(16'h0200)});
            end
            exp_acc.push_back(acc_t'{1'b0, 16'h0040, 32'h0000_0000});
            exp_rsp.push_back(rsp_t'{1'b0, memval(16'h0040)});
        end
        @(negedge clk);
        i_d_wr    = 1'b0;
        i_d_addr  = 16'h0200;
        i_if_addr = 16'h0040;
        i_d_req   = 1'b1;
        i_if_req  = 1'b1;
        drain(300, ok);
        n_checks++;
        if (!ok) $display("FAIL starve_drain: got %0d accesses left, required 0", exp_acc.size());
        else n_pass++;
        last_d_rd  = memval(16'h0200);
        last_if_rd = memval(16'h0040);
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        int dones = 0;
        bit ok;
        mem_lat = 6;
        if_left = 1;
        exp_acc.push_back(acc_t'{1'b0, 16'h0080, 32'h0000_0000});
        @(negedge clk);
        i_if_addr = 16'h0080;
        i_if_req  = 1'b1;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (o_mem_rd) found = 1'b1;
        end
        repeat (2) @(negedge clk);
        #2;
        i_rst = 1'b1;
        #1;
        n_checks++;
        if (!found || o_mem_rd !== 1'b0) $display("FAIL rst_strobe_drop: got found=%b rd=%b, required rd=0", found, o_mem_rd);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (o_if_done || o_d_done) dones++;
        end
        mem_lat = 2;
        exp_acc.push_back(acc_t'{1'b0, 16'h0080, 32'h0000_0000});
        exp_rsp.push_back(rsp_t'{1'b0, memval(16'h0080)});
        i_rst = 1'b0;
        @(negedge clk);
        if (o_if_done || o_d_done) dones++;
        n_checks++;
        if (dones !== 0) $display("FAIL rst_no_done: got %0d done pulses, required 0", dones);
        else n_pass++;
        last_d_rd  = 32'h0000_0000;
        last_if_rd = memval(16'h0080);
        drain(60, ok);
        n_checks++;
        if (!ok) $display("FAIL rst_reissue: got timeout, required completion");
        else n_pass++;
    endtask

    task automatic test_spurious_and_zero_wait();
        int bad = 0;
        int done_cyc = -1;
        int strb = 0;
        bit ok;
        @(negedge clk);
        spur_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (o_if_done || o_d_done || o_mem_rd || o_mem_wr) bad++;
        end
        n_checks++;
        if (bad !== 0) $display("FAIL spur_activity: got %0d active cycles, required 0", bad);
        else n_pass++;
        n_checks++;
        if (o_if_rdata !== last_if_rd || o_d_rdata !== last_d_rd)
            $display("FAIL spur_rdata: got if=%h d=%h, required if=%h d=%h", o_if_rdata, o_d_rdata, last_if_rd, last_d_rd);
        else n_pass++;
        mem_lat = 1;
        d_left  = 1;
        exp_acc.push_back(acc_t'{1'b0, 16'h0500, 32'h0000_0000});
        exp_rsp.push_back(rsp_t'{1'b1, memval(16'h0500)});
        @(negedge clk);
        i_d_wr   = 1'b0;
        i_d_addr = 16'h0500;
        i_d_req  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (o_mem_rd) strb++;
            if (o_d_done) done_cyc = c;
        end
        n_checks++;
        if (done_cyc !== 3 || strb !== 1) $display("FAIL zero_wait: got done cycle %0d strobes %0d, required 3 and 1", done_cyc, strb);
        else n_pass++;
        drain(40, ok);
        n_checks++;
        if (!ok) $display("FAIL zero_wait_drain: got timeout, required completion");
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_addr_change();
        test_starvation();
        test_reset_mid();
        test_spurious_and_zero_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
